// File: rtl/md5_block_feeder_if.sv
// Word-stream link from the block feeder to the MD5 round core.
// The feeder drives one 32-bit message word per transfer; the core
// throttles the stream with w_ready.
interface md5_block_feeder_if;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_data;
    logic [3:0]  w_idx;
    logic        w_last;

    modport master (
        output w_valid,
        output w_data,
        output w_idx,
        output w_last,
        input  w_ready
    );

    modport slave (
        input  w_valid,
        input  w_data,
        input  w_idx,
        input  w_last,
        output w_ready
    );
endinterface

// File: rtl/md5_block_feeder.sv
// md5_block_feeder: turns the current counter candidate into one padded
// 512-bit MD5 block, streams it as sixteen little-endian 32-bit words,
// then steps the counter and repeats until the counter overflows.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for start
// CAPTURE | latch ctr_q into cand, or finish if the counter wrapped
// STREAM  | present word w_idx of the padded block, advance on ready
// STEP    | one-cycle ctr_en pulse to advance the counter
// SETTLE  | let the counter update q before the next capture
// DONE    | candidate space exhausted; held until reset
module md5_block_feeder #(
    parameter int MSG_LEN = 5
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_ctr_en,
    input  logic [127:0]        i_ctr_q,
    input  logic                i_ctr_overflow,
    output logic [127:0]        o_cand,
    output logic [31:0]         o_blk_count,
    md5_block_feeder_if.master  m_word
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_STREAM  = 3'd2,
        ST_STEP    = 3'd3,
        ST_SETTLE  = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [127:0]        r_cand;
    logic [3:0]          r_w_idx;
    logic [31:0]         r_blk_count;

    logic                w_xfer;
    logic                w_busy;
    logic                w_done;
    logic                w_ctr_en;
    logic                w_valid;
    logic [15:0][31:0]   w_block;

    assign w_xfer = (r_state == ST_STREAM) && m_word.w_ready;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (i_start) w_state_nxt = ST_CAPTURE;
            ST_CAPTURE: w_state_nxt = i_ctr_overflow ? ST_DONE : ST_STREAM;
            ST_STREAM:  if (w_xfer && (r_w_idx == 4'd15)) w_state_nxt = ST_STEP;
            ST_STEP:    w_state_nxt = ST_SETTLE;
            ST_SETTLE:  w_state_nxt = ST_CAPTURE;
            ST_DONE:    w_state_nxt = ST_DONE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        w_busy   = 1'b0;
        w_done   = 1'b0;
        w_ctr_en = 1'b0;
        w_valid  = 1'b0;
        case (r_state)
            ST_CAPTURE: w_busy = 1'b1;
            ST_STREAM: begin
                w_busy  = 1'b1;
                w_valid = 1'b1;
            end
            ST_STEP: begin
                w_busy   = 1'b1;
                w_ctr_en = 1'b1;
            end
            ST_SETTLE:  w_busy = 1'b1;
            ST_DONE:    w_done = 1'b1;
            default: ;
        endcase
    end

    // Candidate latch, word index and completed-block counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cand      <= '0;
            r_w_idx     <= '0;
            r_blk_count <= '0;
        end else begin
            if ((r_state == ST_CAPTURE) && !i_ctr_overflow) begin
                r_cand  <= i_ctr_q;
                r_w_idx <= '0;
            end else if (w_xfer) begin
                if (r_w_idx != 4'd15) begin
                    r_w_idx <= r_w_idx + 4'd1;
                end else begin
                    r_blk_count <= r_blk_count + 32'd1;
                end
            end
        end
    end

    // Padded block built from cand; bytes at or above MSG_LEN are masked out
    // so stale upper counter bits can never leak into the message.
    always_comb begin
        w_block = '0;
        for (int b = 0; b < 16; b++) begin
            if (b < MSG_LEN) begin
                w_block[b / 4][8 * (b % 4) +: 8] = r_cand[8 * b +: 8];
            end
        end
        w_block[MSG_LEN / 4][8 * (MSG_LEN % 4) +: 8] = 8'h80;
        w_block[14] = 32'(MSG_LEN * 8);
        w_block[15] = 32'h0000_0000;
    end

    assign m_word.w_valid = w_valid;
    assign m_word.w_data  = w_block[r_w_idx];
    assign m_word.w_idx   = r_w_idx;
    assign m_word.w_last  = w_valid && (r_w_idx == 4'd15);

    assign o_busy      = w_busy;
    assign o_done      = w_done;
    assign o_ctr_en    = w_ctr_en;
    assign o_cand      = r_cand;
    assign o_blk_count = r_blk_count;

endmodule

// File: tb/tb_md5_block_feeder.sv
// Directed bench for md5_block_feeder: a 5-byte instance driven by a small
// counter model, plus an 8-byte instance for the longer message format.
module tb_md5_block_feeder;

    localparam logic [127:0] AA = 128'h61_6161_6161;
    localparam logic [127:0] AB = 128'h61_6161_6162;
    localparam logic [127:0] AC = 128'h61_6161_6163;
    localparam logic [127:0] ZZ = 128'h7A_7A7A_7A7A;
    localparam logic [127:0] Q8 = {64'hFFFF_FFFF_FFFF_FFFF, 64'h3837_3635_3433_3231};

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         start5, ovf5, busy5, done5, en5;
    logic [127:0] ctr_q5, cand5;
    logic [31:0]  blk5;
    logic         start8, busy8, done8, en8;
    logic [127:0] ctr_q8, cand8;
    logic [31:0]  blk8;

    md5_block_feeder_if wif5 ();
    md5_block_feeder_if wif8 ();

    md5_block_feeder #(.MSG_LEN(5)) dut5 (
        .i_clk(clk), .i_rst(rst), .i_start(start5),
        .o_busy(busy5), .o_done(done5), .o_ctr_en(en5),
        .i_ctr_q(ctr_q5), .i_ctr_overflow(ovf5),
        .o_cand(cand5), .o_blk_count(blk5), .m_word(wif5)
    );

    md5_block_feeder #(.MSG_LEN(8)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_start(start8),
        .o_busy(busy8), .o_done(done8), .o_ctr_en(en8),
        .i_ctr_q(ctr_q8), .i_ctr_overflow(1'b0),
        .o_cand(cand8), .o_blk_count(blk8), .m_word(wif8)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          en_count = 0;
    int          dbl_en = 0;
    int          t_first = 0;
    logic        prev_en = 1'b0;
    logic [31:0] exp_w [16];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock; the counter model advances #1 after an edge that saw ctr_en.
    task automatic tick();
        logic en_before;
        en_before = en5;
        @(posedge clk);
        #1;
        cyc++;
        if (en_before) begin
            en_count++;
            if (prev_en) dbl_en++;
            if (ctr_q5 == ZZ) begin
                ctr_q5 = AA;
                ovf5   = 1'b1;
            end else begin
                ctr_q5 = ctr_q5 + 128'd1;
            end
        end
        prev_en = en_before;
    endtask

    task automatic set_exp(input logic [31:0] w0, input logic [31:0] w1);
        for (int i = 0; i < 16; i++) exp_w[i] = 32'h0;
        exp_w[0]  = w0;
        exp_w[1]  = w1;
        exp_w[14] = 32'h0000_0028;
    endtask

    task automatic stream5(input int blk, input int from);
        for (int i = from; i < 16; i++) begin
            chk($sformatf("b%0d_valid%0d", blk, i), 128'(wif5.w_valid), 128'd1);
            chk($sformatf("b%0d_idx%0d", blk, i), 128'(wif5.w_idx), 128'(i));
            chk($sformatf("b%0d_data%0d", blk, i), 128'(wif5.w_data), 128'(exp_w[i]));
            chk($sformatf("b%0d_last%0d", blk, i), 128'(wif5.w_last), 128'(i == 15));
            chk($sformatf("b%0d_en%0d", blk, i), 128'(en5), 128'd0);
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; start5 = 1'b0; ovf5 = 1'b0; ctr_q5 = AA; wif5.w_ready = 1'b1;
        start8 = 1'b0; ctr_q8 = Q8; wif8.w_ready = 1'b1;
        tick();
        tick();

        // reset state
        chk("rst_busy", 128'(busy5), 128'd0);
        chk("rst_done", 128'(done5), 128'd0);
        chk("rst_valid", 128'(wif5.w_valid), 128'd0);
        chk("rst_en", 128'(en5), 128'd0);
        chk("rst_idx", 128'(wif5.w_idx), 128'd0);
        chk("rst_cand", cand5, 128'd0);
        chk("rst_blk", 128'(blk5), 128'd0);
        chk("rst_valid8", 128'(wif8.w_valid), 128'd0);
        rst = 1'b0;
        tick();
        chk("idle_hold_busy", 128'(busy5), 128'd0);

        // block 1: aaaaa with ready high
        start5 = 1'b1;
        tick();
        start5 = 1'b0;
        chk("cap_busy", 128'(busy5), 128'd1);
        chk("cap_valid", 128'(wif5.w_valid), 128'd0);
        tick();
        t_first = cyc;
        chk("b1_cand", cand5, AA);
        set_exp(32'h6161_6161, 32'h0000_8061);
        stream5(1, 0);
        chk("b1_step_en", 128'(en5), 128'd1);
        chk("b1_step_valid", 128'(wif5.w_valid), 128'd0);
        chk("b1_blk", 128'(blk5), 128'd1);
        tick();
        chk("b1_settle_en", 128'(en5), 128'd0);
        chk("b1_en_count", 128'(en_count), 128'd1);
        tick();
        tick();

        // block 2: aaaab, stall for 5 cycles at word 7
        chk("b2_spacing", 128'(cyc - t_first), 128'd19);
        chk("b2_cand", cand5, AB);
        set_exp(32'h6161_6162, 32'h0000_8061);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("b2_idx%0d", i), 128'(wif5.w_idx), 128'(i));
            chk($sformatf("b2_data%0d", i), 128'(wif5.w_data), 128'(exp_w[i]));
            tick();
        end
        wif5.w_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall_valid%0d", k), 128'(wif5.w_valid), 128'd1);
            chk($sformatf("stall_idx%0d", k), 128'(wif5.w_idx), 128'd7);
            chk($sformatf("stall_data%0d", k), 128'(wif5.w_data), 128'd0);
            chk($sformatf("stall_en%0d", k), 128'(en5), 128'd0);
            tick();
        end
        wif5.w_ready = 1'b1;
        stream5(2, 7);
        chk("b2_blk", 128'(blk5), 128'd2);
        tick();
        tick();
        tick();

        // block 3: aaaac, reset at word 9
        chk("b3_cand", cand5, AC);
        for (int i = 0; i < 9; i++) tick();
        chk("b3_idx9", 128'(wif5.w_idx), 128'd9);
        rst = 1'b1;
        tick();
        chk("mrst_valid", 128'(wif5.w_valid), 128'd0);
        chk("mrst_busy", 128'(busy5), 128'd0);
        chk("mrst_blk", 128'(blk5), 128'd0);
        chk("mrst_idx", 128'(wif5.w_idx), 128'd0);
        rst = 1'b0;
        tick();
        chk("mrst_idle", 128'(busy5), 128'd0);
        start5 = 1'b1;
        tick();
        start5 = 1'b0;
        tick();
        chk("b4_cand", cand5, AC);
        set_exp(32'h6161_6163, 32'h0000_8061);
        stream5(4, 0);
        chk("b4_blk", 128'(blk5), 128'd1);
        tick();

        // block 5: zzzzz, then overflow on the next advance
        ctr_q5 = ZZ;
        tick();
        tick();
        chk("b5_cand", cand5, ZZ);
        set_exp(32'h7A7A_7A7A, 32'h0000_807A);
        stream5(5, 0);
        chk("b5_blk", 128'(blk5), 128'd2);
        tick();
        tick();
        chk("ovf_cap_busy", 128'(busy5), 128'd1);
        chk("ovf_cap_done", 128'(done5), 128'd0);
        tick();
        chk("done_done", 128'(done5), 128'd1);
        chk("done_busy", 128'(busy5), 128'd0);
        chk("done_valid", 128'(wif5.w_valid), 128'd0);
        start5 = 1'b1;
        tick();
        start5 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("done_hold_valid%0d", k), 128'(wif5.w_valid), 128'd0);
            chk($sformatf("done_hold_en%0d", k), 128'(en5), 128'd0);
            chk($sformatf("done_hold_done%0d", k), 128'(done5), 128'd1);
            tick();
        end
        chk("done_blk", 128'(blk5), 128'd2);
        chk("done_cand", cand5, ZZ);
        chk("en_pulses", 128'(en_count), 128'd4);
        chk("en_back_to_back", 128'(dbl_en), 128'd0);

        // 8-byte message with 0xFF in the unused candidate bytes
        for (int i = 0; i < 16; i++) exp_w[i] = 32'h0;
        exp_w[0]  = 32'h3433_3231;
        exp_w[1]  = 32'h3837_3635;
        exp_w[2]  = 32'h0000_0080;
        exp_w[14] = 32'h0000_0040;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        chk("m8_cand", cand8, Q8);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("m8_valid%0d", i), 128'(wif8.w_valid), 128'd1);
            chk($sformatf("m8_idx%0d", i), 128'(wif8.w_idx), 128'(i));
            chk($sformatf("m8_data%0d", i), 128'(wif8.w_data), 128'(exp_w[i]));
            chk($sformatf("m8_last%0d", i), 128'(wif8.w_last), 128'(i == 15));
            tick();
        end
        chk("m8_step_en", 128'(en8), 128'd1);
        chk("m8_blk", 128'(blk8), 128'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
